// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter stage and its request queue bank.
package arb_pkg;

  localparam int ARB_W = 16;

  typedef logic [ARB_W-1:0] arb_data_t;

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Single-lane synchronous FIFO feeding one arbiter request lane; head is purely registered.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = ARB_W,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_live,
  input  logic          i_push_valid,
  input  logic [W-1:0]  i_push_data,
  output logic          o_push_ready,
  output logic          o_head_valid,
  output logic [W-1:0]  o_head_data,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output logic          o_underflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          not_empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));

  // Ready depends only on registered state, never on the grant of this cycle.
  assign o_push_ready = i_live && !full;
  assign do_push      = i_push_valid && o_push_ready;
  assign do_pop       = i_pop && not_empty;
  assign o_underflow  = i_pop && !not_empty;

  assign o_head_valid = not_empty;
  assign o_head_data  = not_empty ? mem[rd_ptr] : '0;
  assign o_count      = count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_queue_bank.sv
// Bank of per-requester FIFOs upstream of the round-robin arbiter, with sticky grant error flags.
module arb_req_queue_bank
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int DEPTH = 4,
  parameter int W = ARB_W,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [N-1:0]         i_push_valid,
  input  logic [W-1:0]         i_push_data [N],
  output logic [N-1:0]         o_push_ready,
  output logic [N-1:0]         o_req_valid,
  output logic [W-1:0]         o_req_data [N],
  input  logic [N-1:0]         i_grant,
  output logic [N-1:0][CW-1:0] o_count,
  output logic                 o_underflow,
  output logic                 o_grant_err
);

  logic         r_live;
  logic [N-1:0] lane_underflow;
  logic         multi_grant;

  for (genvar g = 0; g < N; g++) begin : g_lane
    arb_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_live       (r_live),
      .i_push_valid (i_push_valid[g]),
      .i_push_data  (i_push_data[g]),
      .o_push_ready (o_push_ready[g]),
      .o_head_valid (o_req_valid[g]),
      .o_head_data  (o_req_data[g]),
      .i_pop        (i_grant[g]),
      .o_count      (o_count[g]),
      .o_underflow  (lane_underflow[g])
    );
  end

  assign multi_grant = ($countones(i_grant) > 1);

  // r_live holds ready low for the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_live      <= 1'b0;
      o_underflow <= 1'b0;
      o_grant_err <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      o_underflow <= o_underflow | (|lane_underflow);
      o_grant_err <= o_grant_err | multi_grant;
    end
  end

endmodule

// File: tb/tb_arb_req_queue_bank.sv
// Directed self-checking bench for arb_req_queue_bank (N=4, DEPTH=4, W=16).
module tb_arb_req_queue_bank;
  import arb_pkg::*;

  localparam int N = 4;
  localparam int DEPTH = 4;
  localparam int W = ARB_W;
  localparam int CW = cnt_w(DEPTH);

  logic                 i_clk;
  logic                 i_reset_n;
  logic [N-1:0]         i_push_valid;
  logic [W-1:0]         i_push_data [N];
  logic [N-1:0]         o_push_ready;
  logic [N-1:0]         o_req_valid;
  logic [W-1:0]         o_req_data [N];
  logic [N-1:0]         i_grant;
  logic [N-1:0][CW-1:0] o_count;
  logic                 o_underflow;
  logic                 o_grant_err;

  int n_checks = 0;
  int n_fail = 0;

  arb_req_queue_bank #(.N(N), .DEPTH(DEPTH), .W(W)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_push_valid (i_push_valid),
    .i_push_data  (i_push_data),
    .o_push_ready (o_push_ready),
    .o_req_valid  (o_req_valid),
    .o_req_data   (o_req_data),
    .i_grant      (i_grant),
    .o_count      (o_count),
    .o_underflow  (o_underflow),
    .o_grant_err  (o_grant_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one active edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_push_valid = 4'b1111;
    i_grant      = '0;
    for (int i = 0; i < N; i++) i_push_data[i] = 16'hDEAD;

    // Reset state and ready-enable sequencing
    step();
    step();
    chk("rst_ready", 32'(o_push_ready), 32'h0);
    chk("rst_valid", 32'(o_req_valid), 32'h0);
    chk("rst_count", 32'(o_count), 32'h0);
    chk("rst_flags", {30'd0, o_underflow, o_grant_err}, 32'h0);
    i_reset_n = 1'b1;
    #1;
    chk("rel_ready_c1", 32'(o_push_ready), 32'h0);
    step();
    chk("rel_ready_c2", 32'(o_push_ready), 32'hF);
    chk("rel_valid", 32'(o_req_valid), 32'h0);
    i_push_valid = '0;

    // Single-lane latency and order on lane 2
    i_push_data[2] = 16'h1111;
    i_push_valid   = 4'b0100;
    step();
    chk("l2_valid_lat", 32'(o_req_valid), 32'h4);
    chk("l2_head0", 32'(o_req_data[2]), 32'h1111);
    i_push_data[2] = 16'h2222;
    step();
    i_push_data[2] = 16'h3333;
    step();
    i_push_valid = '0;
    chk("l2_count3", 32'(o_count[2]), 32'd3);
    chk("l2_head_hold", 32'(o_req_data[2]), 32'h1111);
    i_grant = 4'b0100;
    step();
    chk("l2_pop1", 32'(o_req_data[2]), 32'h2222);
    step();
    chk("l2_pop2", 32'(o_req_data[2]), 32'h3333);
    step();
    i_grant = '0;
    chk("l2_empty_valid", 32'(o_req_valid[2]), 32'h0);
    chk("l2_empty_data", 32'(o_req_data[2]), 32'h0);
    chk("l2_no_uf", 32'(o_underflow), 32'h0);

    // Full / backpressure on lane 0: five words, DEPTH=4
    i_push_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      i_push_data[0] = 16'hA000 + 16'(k);
      step();
    end
    chk("l0_full_ready", 32'(o_push_ready[0]), 32'h0);
    chk("l0_full_count", 32'(o_count[0]), 32'd4);
    i_push_data[0] = 16'hA004;
    step();
    chk("l0_held_count", 32'(o_count[0]), 32'd4);
    chk("l0_held_head", 32'(o_req_data[0]), 32'hA000);
    i_grant = 4'b0001;
    step();
    i_grant = '0;
    chk("l0_pop_count", 32'(o_count[0]), 32'd3);
    chk("l0_ready_back", 32'(o_push_ready[0]), 32'h1);
    step();
    i_push_valid = '0;
    chk("l0_fifth_in", 32'(o_count[0]), 32'd4);
    i_grant = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("l0_order%0d", k), 32'(o_req_data[0]), 32'hA000 + 32'(k));
      step();
    end
    i_grant = '0;
    chk("l0_drained", 32'(o_count[0]), 32'd0);

    // Simultaneous push+pop on lane 1, running across pointer wrap
    i_push_valid = 4'b0010;
    i_push_data[1] = 16'hB000;
    step();
    i_push_data[1] = 16'hB001;
    step();
    chk("l1_count2", 32'(o_count[1]), 32'd2);
    i_grant = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      i_push_data[1] = 16'hB002 + 16'(k);
      step();
      chk($sformatf("l1_pp_count%0d", k), 32'(o_count[1]), 32'd2);
      chk($sformatf("l1_pp_head%0d", k), 32'(o_req_data[1]), 32'hB001 + 32'(k));
    end
    i_push_valid = '0;
    step();
    chk("l1_tail", 32'(o_req_data[1]), 32'hB00B);
    step();
    i_grant = '0;
    chk("l1_drained", 32'(o_count[1]), 32'd0);

    // Error flags
    i_grant = 4'b1000;
    step();
    i_grant = '0;
    chk("uf_set", 32'(o_underflow), 32'h1);
    chk("uf_counts", 32'(o_count), 32'h0);
    chk("ge_clear", 32'(o_grant_err), 32'h0);
    i_push_valid = 4'b0011;
    i_push_data[0] = 16'hC000;
    i_push_data[1] = 16'hC001;
    step();
    i_push_valid = '0;
    i_grant = 4'b0011;
    step();
    i_grant = '0;
    chk("ge_set", 32'(o_grant_err), 32'h1);
    chk("ge_both_pop", 32'(o_count), 32'h0);
    step();
    step();
    chk("flags_sticky", {30'd0, o_underflow, o_grant_err}, 32'h3);

    // Reset mid-operation
    i_push_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) i_push_data[i] = 16'hE000 + 16'(i * 16 + k);
      step();
    end
    i_push_valid = '0;
    chk("mid_count3", 32'(o_count), {20'd0, 3'd3, 3'd3, 3'd3, 3'd3});
    chk("mid_valid", 32'(o_req_valid), 32'hF);
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_req_valid), 32'h0);
    chk("mid_rst_count", 32'(o_count), 32'h0);
    chk("mid_rst_flags", {30'd0, o_underflow, o_grant_err}, 32'h0);
    chk("mid_rst_ready", 32'(o_push_ready), 32'h0);
    step();
    i_reset_n = 1'b1;
    #1;
    chk("mid_rel_ready_c1", 32'(o_push_ready), 32'h0);
    step();
    chk("mid_rel_ready_c2", 32'(o_push_ready), 32'hF);
    step();
    chk("mid_no_stale_valid", 32'(o_req_valid), 32'h0);
    for (int i = 0; i < N; i++)
      chk($sformatf("mid_no_stale_data%0d", i), 32'(o_req_data[i]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
